mac_operand_feeder: RTL
=======================

Name: mac_operand_feeder

Overview:
Upstream sequencer for the 16x16 multiply-accumulate unit (36-bit accumulator). It buffers incoming operand pairs in a small FIFO. On a start command it clears the MAC accumulator and issues exactly len pairs, one per cycle, onto the MAC a/b inputs. It then waits out the MAC latency and pulses done when the MAC result is final. Idle and bubble cycles drive a=b=0, which leaves the accumulator unchanged.

Parameters:
DATA_W, 16, operand width (matches MAC a/b)
DEPTH, 8, FIFO entries (power of 2, >=2)
LEN_W, 8, width of the pair-count command
MAC_LAT, 1, cycles from a pair on mac_a/mac_b to the accumulator holding its product

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-low; all state cleared on the rising clk edge while low
in_valid  in  1  operand pair offered
in_ready  out  1  FIFO can accept; equals !full, registered
in_a  in  DATA_W  operand a
in_b  in  DATA_W  operand b
start  in  1  begin a dot product; sampled only in IDLE
len  in  LEN_W  number of pairs to accumulate; sampled with start
busy  out  1  high in every state except IDLE
mac_a  out  DATA_W  to MAC a, registered
mac_b  out  DATA_W  to MAC b, registered
mac_clr  out  1  accumulator clear request to MAC reset, active-high, one cycle
done  out  1  one-cycle pulse; MAC output c is final in this cycle

Behaviour:
- Reset values: mac_a=0, mac_b=0, mac_clr=0, done=0, busy=0, in_ready=0 while reset is low. in_ready goes to 1 on the first edge after release. FIFO is flushed; FSM goes to IDLE.
- Reset mid-operation aborts the job: remaining count is discarded, FIFO contents are lost, no done pulse.
- Push occurs when in_valid && in_ready, in any state including IDLE. Push while full is impossible because in_ready is low.
- There is no bypass. A pair pushed in cycle t can pop at the earliest in cycle t+1. Push and pop in the same cycle leave the count unchanged.
- FSM states: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE: mac_a/mac_b=0. On start, latch len into rem and go to CLEAR. start in any other state is ignored.
- CLEAR: mac_clr=1 for exactly one cycle; mac_a/mac_b=0.
  - Next state is RUN if rem!=0.
  - Next state is DRAIN if rem==0 (result is 0).
- RUN: each cycle the FIFO is non-empty, pop one pair and register it onto mac_a/mac_b on the next edge, then decrement rem.
  - Empty FIFO: drive 0/0 (bubble); rem is unchanged.
  - The pop that makes rem==0 moves the FSM to DRAIN.
- DRAIN: MAC_LAT+1 cycles of mac_a/mac_b=0. This covers the output register plus the MAC latency. Then go to DONE.
- DONE: done=1 for one cycle, then IDLE. Pairs left in the FIFO are kept for the next job.
- Arithmetic:
  - rem is LEN_W bits, decremented only on pop, never below 0.
  - len max = 2^LEN_W-1.
  - No truncation of operands.
- Throughput: one pair per cycle while the FIFO stays non-empty. Job latency with no bubbles = 1 (CLEAR) + len + MAC_LAT+1 + 1 (DONE) cycles from the start edge.

Optional Feature:
FEEDER_STALL_CNT_EN:
- Defined: adds output stall_cnt (16 bits). It counts RUN cycles with an empty FIFO, saturates at 0xFFFF, clears to 0 on accepted start and on reset, and holds its value after done.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mac_pkg:
  - DATA_W=16, ACC_W=36
  - FSM state typedef/encodings: IDLE=0, CLEAR=1, RUN=2, DRAIN=3, DONE=4
- One sub-module: mac_operand_fifo.
  - Synchronous FIFO with DEPTH entries and 2*DATA_W-wide data.
  - Interface: push, pop, full, empty, count.
  - Same clk/reset.

Test Plan:
- Pre-load (0,4),(1,6),(4,17),(9,34); start, len=4 -> mac_clr one cycle, 4 consecutive pairs on mac_a/b, done after 1+4+2+1 cycles; MAC c=380.
- Same 4 pairs pushed one every 3 cycles after start -> 0/0 bubbles between pairs, done still fires, c=380; with FEEDER_STALL_CNT_EN, stall_cnt equals the bubble count.
- start with len=0 -> mac_clr pulse, no pops, done 4 cycles later, c=0, FIFO count unchanged.
- Push 9 pairs with DEPTH=8 and no job running -> in_ready low after 8th push, 9th held by source; start len=8 -> in_ready rises the cycle after the first pop, 9th accepted.
- Push 5 pairs, start len=3 -> exactly 3 popped, done, 2 remain; second start len=2 consumes them and c equals their product sum.
- Assert reset low mid-RUN after 2 of 4 pairs -> next edge: all outputs 0, busy=0, FIFO empty, no done; a new job after release runs normally.
- Start pulsed again during RUN -> ignored, rem unaffected.

Source files
------------

// File: rtl/mac_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mac_pkg : shared widths and FSM state encoding for the MAC operand feeder  |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
package mac_pkg;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 36;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } feeder_state_t;
endpackage
`default_nettype wire

// File: rtl/mac_operand_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mac_operand_fifo : synchronous FIFO holding packed {a,b} operand pairs     |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module mac_operand_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage is not reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
endmodule
`default_nettype wire

// File: rtl/mac_operand_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mac_operand_feeder : buffers operand pairs and issues len pairs to the MAC |
// | Optional macro FEEDER_STALL_CNT_EN adds the stall_cnt output.              |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module mac_operand_feeder #(
  parameter int DATA_W  = mac_pkg::DATA_W,
  parameter int DEPTH   = 8,
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  output logic              mac_clr,
  output logic              done
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);
  import mac_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int DRN_W = $clog2(MAC_LAT + 2);

  feeder_state_t       state;
  feeder_state_t       state_nx;
  logic [LEN_W-1:0]    rem;
  logic [DRN_W-1:0]    drain_cnt;
  logic                push;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic [2*DATA_W-1:0] fifo_rdata;

  assign push = in_valid && in_ready;
  assign pop  = (state == ST_RUN) && !fifo_empty;

  mac_operand_fifo #(
    .WIDTH (2*DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({in_a, in_b}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    mac_clr  = 1'b0;
    done     = 1'b0;
    busy     = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = ST_CLEAR;
      end
      ST_CLEAR: begin
        mac_clr  = 1'b1;
        state_nx = (rem != '0) ? ST_RUN : ST_DRAIN;
      end
      ST_RUN: begin
        if (pop && rem == LEN_W'(1)) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_cnt == DRN_W'(MAC_LAT)) state_nx = ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rem       <= '0;
      drain_cnt <= '0;
      mac_a     <= '0;
      mac_b     <= '0;
      in_ready  <= 1'b0;
    end else begin
      // Next-cycle full: stays full without a pop, or the last free slot fills now.
      in_ready <= !((fifo_full && !pop) ||
                    (fifo_count == CNT_W'(DEPTH-1) && push && !pop));
      {mac_a, mac_b} <= pop ? fifo_rdata : '0;
      if (state == ST_IDLE && start) rem <= len;
      else if (pop)                  rem <= rem - 1'b1;
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 1'b1 : '0;
    end
  end

`ifdef FEEDER_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset)
      stall_cnt <= '0;
    else if (state == ST_IDLE && start)
      stall_cnt <= '0;
    else if (state == ST_RUN && fifo_empty && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 1'b1;
  end
`endif
endmodule
`default_nettype wire
